key_pulse_gen: RTL and testbench

KEY_PULSE_GEN -- requirements
Module: key_pulse_gen

---
 rtl/key_pulse_pkg.sv | 13 +
 rtl/key_pulse_gen_sync_chain.sv | 15 +
 rtl/key_pulse_gen.sv | 85 ++++++++
 tb/tb_key_pulse_gen.sv | 135 +++++++++++++
 4 files changed

// File: rtl/key_pulse_pkg.sv
// key_pulse_pkg: shared FSM encodings and sizing helper for key_pulse_gen
package key_pulse_pkg;
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_DB_PRESS   = 3'd1;
  localparam logic [2:0] ST_HELD       = 3'd2;
  localparam logic [2:0] ST_REPEAT     = 3'd3;
  localparam logic [2:0] ST_DB_RELEASE = 3'd4;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/key_pulse_gen_sync_chain.sv
// sync_chain: resettable multi-flop synchronizer for an asynchronous level
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic [SYNC_STAGES-1:0] s_q;
  // shift the raw level toward the last stage; reset flushes any stale press
  always_ff @(posedge clock)
    s_q <= reset ? '0 : {s_q[SYNC_STAGES-2:0], d_i};
  assign q_o = s_q[SYNC_STAGES-1];
endmodule

// File: rtl/key_pulse_gen.sv
// key_pulse_gen: debounced pushbutton to one-cycle pulse with optional auto-repeat
module key_pulse_gen
  import key_pulse_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic key,
  output logic pulse,
  output logic keyDown,
  output logic repeating
);
  localparam int TW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [TW-1:0] DB_LAST  = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);
  logic key_lvl, key_sync, pulse_d, reload;
  logic [2:0] state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic pulse_q, key_down_q, repeating_q;
  assign key_lvl = (KEY_ACTIVE_LOW != 0) ? ~key : key;
  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock(clock),
    .reset(reset),
    .d_i  (key_lvl),
    .q_o  (key_sync)
  );
  // next state, pulse request and timer; a key change always beats a timer expiry
  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    reload  = 1'b0;
    case (state_q)
      ST_IDLE:       state_d = key_sync ? ST_DB_PRESS : ST_IDLE;
      ST_DB_PRESS:
        if (!key_sync) state_d = ST_IDLE;
        else if (timer_q == DB_LAST) begin
          state_d = ST_HELD;
          pulse_d = 1'b1;
        end
      ST_HELD:
        if (!key_sync) state_d = ST_DB_RELEASE;
        else if (REPEAT_EN != 0 && timer_q == DLY_LAST) begin
          state_d = ST_REPEAT;
          pulse_d = 1'b1;
        end
      ST_REPEAT:
        if (!key_sync) state_d = ST_DB_RELEASE;
        else if (timer_q == PER_LAST) begin
          reload  = 1'b1;
          pulse_d = 1'b1;
        end
      ST_DB_RELEASE:
        if (key_sync) state_d = ST_HELD;
        else if (timer_q == DB_LAST) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
    timer_d = (reload || state_d != state_q) ? '0 : timer_q + TW'(~&timer_q);
  end
  // register state, timer and all outputs so nothing combinational reaches a port
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      pulse_q     <= 1'b0;
      key_down_q  <= 1'b0;
      repeating_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pulse_q     <= pulse_d;
      key_down_q  <= (state_d == ST_HELD) || (state_d == ST_REPEAT) || (state_d == ST_DB_RELEASE);
      repeating_q <= state_d == ST_REPEAT;
    end
  end
  assign pulse     = pulse_q;
  assign keyDown   = key_down_q;
  assign repeating = repeating_q;
endmodule

// File: tb/tb_key_pulse_gen.sv
// tb_key_pulse_gen: directed and random stimulus against a run-length reference model
module tb_key_pulse_gen;
  import key_pulse_pkg::*;
  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  logic clock = 1'b0, reset = 1'b1, key_l = 1'b0, key_n;
  logic pulse0, down0, rep0, pulse1, down1, rep1;
  int checks = 0, errors = 0;
  int edge_n, cnt0, cnt1, first0;
  bit rep1_seen, down_seen, dropped;
  logic [1:0] hist = '0;
  int run [2], rel [2], age [2];
  bit dn [2], rp [2], pe [2];
  always #5 clock = ~clock;
  assign key_n = ~key_l;
  key_pulse_gen #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(DC), .REPEAT_EN(1), .REPEAT_DELAY(RD),
                  .REPEAT_PERIOD(RP), .KEY_ACTIVE_LOW(0)) dut_rpt (
    .clock(clock), .reset(reset), .key(key_l),
    .pulse(pulse0), .keyDown(down0), .repeating(rep0));
  key_pulse_gen #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(DC), .REPEAT_EN(0), .REPEAT_DELAY(RD),
                  .REPEAT_PERIOD(RP), .KEY_ACTIVE_LOW(1)) dut_one (
    .clock(clock), .reset(reset), .key(key_n),
    .pulse(pulse1), .keyDown(down1), .repeating(rep1));
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_step();
    bit ks;
    ks = hist[1];
    hist = reset ? 2'b00 : {hist[0], key_l};
    for (int m = 0; m < 2; m++) begin
      pe[m] = 1'b0;
      if (reset) begin
        run[m] = 0; rel[m] = 0; age[m] = 0; dn[m] = 1'b0; rp[m] = 1'b0;
      end else if (!dn[m]) begin
        run[m] = ks ? run[m] + 1 : 0;
        if (run[m] == DC + 1) begin
          dn[m] = 1'b1; pe[m] = 1'b1; age[m] = 0; run[m] = 0;
        end
      end else if (!ks) begin
        rp[m] = 1'b0;
        rel[m]++;
        if (rel[m] == DC + 1) begin
          dn[m] = 1'b0; rel[m] = 0;
        end
      end else if (rel[m] > 0) begin
        rel[m] = 0; age[m] = 0;
      end else begin
        age[m]++;
        if (!rp[m] && m == 0 && age[m] == RD) begin
          rp[m] = 1'b1; pe[m] = 1'b1; age[m] = 0;
        end else if (rp[m] && age[m] == RP) begin
          pe[m] = 1'b1; age[m] = 0;
        end
      end
    end
  endtask
  task automatic cyc(input logic k, input logic r);
    key_l = k;
    reset = r;
    @(posedge clock);
    model_step();
    #1;
    chk("pulse_a", int'(pulse0), int'(pe[0]));
    chk("down_a",  int'(down0),  int'(dn[0]));
    chk("rep_a",   int'(rep0),   int'(rp[0]));
    chk("pulse_b", int'(pulse1), int'(pe[1]));
    chk("down_b",  int'(down1),  int'(dn[1]));
    chk("rep_b",   int'(rep1),   int'(rp[1]));
    edge_n++;
    if (pulse0) begin
      cnt0++;
      if (first0 < 0) first0 = edge_n;
    end
    if (pulse1) cnt1++;
    if (rep1) rep1_seen = 1'b1;
    if (down0 || down1) down_seen = 1'b1;
    if (first0 > 0 && !down0) dropped = 1'b1;
  endtask
  task automatic clr();
    edge_n = 0; cnt0 = 0; cnt1 = 0; first0 = -1;
    rep1_seen = 1'b0; down_seen = 1'b0; dropped = 1'b0;
  endtask
  initial begin
    for (int m = 0; m < 2; m++) begin
      run[m] = 0; rel[m] = 0; age[m] = 0; dn[m] = 1'b0; rp[m] = 1'b0; pe[m] = 1'b0;
    end
    clr();
    repeat (3) cyc(1'b0, 1'b1);
    chk("reset_outs", int'({pulse0, down0, rep0, pulse1, down1, rep1}), 0);
    clr();
    repeat (40) cyc(1'b1, 1'b0);
    chk("press_latency", first0, 7);
    chk("repeat_count", cnt0, 9);
    chk("single_count", cnt1, 1);
    chk("no_repeat_flag", int'(rep1_seen), 0);
    repeat (10) cyc(1'b0, 1'b0);
    clr();
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
    repeat (10) cyc(1'b0, 1'b0);
    chk("bounce_pulses", cnt0 + cnt1, 0);
    chk("bounce_down", int'(down_seen), 0);
    clr();
    repeat (12) cyc(1'b1, 1'b0);
    repeat (2) cyc(1'b0, 1'b0);
    repeat (8) cyc(1'b1, 1'b0);
    chk("glitch_pulses", cnt0, 1);
    chk("glitch_down", int'(dropped), 0);
    repeat (10) cyc(1'b0, 1'b0);
    clr();
    repeat (19) cyc(1'b1, 1'b0);
    chk("in_repeat", int'(rep0), 1);
    cyc(1'b1, 1'b1);
    chk("rst_outs", int'({pulse0, down0, rep0}), 0);
    clr();
    repeat (20) cyc(1'b1, 1'b0);
    chk("rst_relatch", first0, 7);
    repeat (10) cyc(1'b0, 1'b0);
    for (int s = 0; s < 250; s++) begin
      logic k, r;
      int len;
      k = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 30) == 0);
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 6);
      for (int i = 0; i < len; i++) cyc(k, r && i < 2);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
